shift_reg_arbiter: RTL and testbench

Shares one serial shift_register chain between up to 8 independent requesters, e.g. digit driver, LED bar and status LEDs. It picks one requester by round robin and latches that requester's parallel word. It then issues the start strobe to shift_register, tracks its busy flag through the whole transfer, and returns a one-cycle acknowledge to the winner. It sits between the display/LED logic and shift_register, in the same i_clk domain as the shift-clock divider.

---
 rtl/shift_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_shift_reg_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter sharing one serial shift_register among NUM_REQ requesters.
// It latches the winner's word, strobes the shifter, follows busy and acks the winner.
module shift_reg_arbiter #(
   parameter int WIDTH        = 8,
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 256
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [NUM_REQ*WIDTH-1:0]   i_data,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [NUM_REQ-1:0]         o_ack,
   output logic                       o_active,
   output logic                       o_timeout_stb,
   output logic                       o_start_stb,
   output logic [WIDTH-1:0]           o_parallel_data,
   input  logic                       i_sr_busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, ACK} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 active_q, active_d;
   logic                 timeout_stb_q, timeout_stb_d;
   logic                 start_stb_q, start_stb_d;
   logic [WIDTH-1:0]     pdata_q, pdata_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W:0]       pick_res;
   logic                 sel_found;
   logic [IDX_W-1:0]     sel_idx;

   // Nearest set bit above the pointer wins; the pointer itself is tried last.
   function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IDX_W-1:0]   ptr);
      logic [IDX_W:0] r;
      int             j;
      r = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (req[j]) r = {1'b1, IDX_W'(j)};
      end
      return r;
   endfunction

   assign pick_res  = pick(i_req, ptr_q);
   assign sel_found = pick_res[IDX_W];
   assign sel_idx   = pick_res[IDX_W-1:0];

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ack_d         = '0;
      timeout_stb_d = 1'b0;
      start_stb_d   = 1'b0;
      pdata_d       = pdata_q;
      ptr_d         = ptr_q;
      gidx_d        = gidx_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               gidx_d  = sel_idx;
               grant_d = NUM_REQ'(1) << sel_idx;
               pdata_d = i_data[int'(sel_idx)*WIDTH +: WIDTH];
               state_d = START;
            end
         end
         START: begin
            start_stb_d = 1'b1;
            cnt_d       = '0;
            state_d     = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // Count reaching BUSY_TIMEOUT marks the cycle the timeout strobe is out.
            if (cnt_q == CNT_W'(BUSY_TIMEOUT)) begin
               ack_d   = grant_q;
               state_d = ACK;
            end else if (i_sr_busy) begin
               state_d = WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) timeout_stb_d = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!i_sr_busy) begin
               ack_d   = grant_q;
               state_d = ACK;
            end
         end
         ACK: begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      active_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         ack_q         <= '0;
         active_q      <= 1'b0;
         timeout_stb_q <= 1'b0;
         start_stb_q   <= 1'b0;
         pdata_q       <= '0;
         ptr_q         <= IDX_W'(NUM_REQ - 1);
         gidx_q        <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         active_q      <= active_d;
         timeout_stb_q <= timeout_stb_d;
         start_stb_q   <= start_stb_d;
         pdata_q       <= pdata_d;
         ptr_q         <= ptr_d;
         gidx_q        <= gidx_d;
         cnt_q         <= cnt_d;
      end
   end

   assign o_grant         = grant_q;
   assign o_ack           = ack_q;
   assign o_active        = active_q;
   assign o_timeout_stb   = timeout_stb_q;
   assign o_start_stb     = start_stb_q;
   assign o_parallel_data = pdata_q;

endmodule

// File: tb/tb_shift_reg_arbiter.sv
// Directed bench for shift_reg_arbiter with a behavioural shift_register busy model
// and a scoreboard of expected {ack, shifted word} pairs.
module tb_shift_reg_arbiter;

   localparam int WIDTH        = 8;
   localparam int NUM_REQ      = 4;
   localparam int BUSY_TIMEOUT = 256;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       i_req;
   logic [NUM_REQ*WIDTH-1:0] i_data;
   logic [NUM_REQ-1:0]       o_grant;
   logic [NUM_REQ-1:0]       o_ack;
   logic                     o_active;
   logic                     o_timeout_stb;
   logic                     o_start_stb;
   logic [WIDTH-1:0]         o_parallel_data;
   logic                     sr_busy;

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_q[$];

   // shift_register model
   bit         busy_en  = 1'b1;
   int         busy_len = 4;
   int         busy_cnt;
   logic [7:0] cap_word;

   always #5 clk = ~clk;

   shift_reg_arbiter #(
      .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(i_req), .i_data(i_data),
      .o_grant(o_grant), .o_ack(o_ack), .o_active(o_active),
      .o_timeout_stb(o_timeout_stb), .o_start_stb(o_start_stb),
      .o_parallel_data(o_parallel_data), .i_sr_busy(sr_busy)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= 0;
         sr_busy  <= 1'b0;
         cap_word <= 8'h00;
      end else if (o_start_stb) begin
         cap_word <= o_parallel_data;
         busy_cnt <= busy_len;
         sr_busy  <= busy_en;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         sr_busy  <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every ack must match the oldest pending transfer.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_ack !== '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(o_ack), 32'h0);
         end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            chk("sb_ack", 32'(o_ack), 32'(e[11:8]));
            chk("sb_word", 32'(cap_word), 32'(e[7:0]));
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant"}, 32'(o_grant), 0);
      chk({tag, "_ack"}, 32'(o_ack), 0);
      chk({tag, "_active"}, 32'(o_active), 0);
      chk({tag, "_timeout"}, 32'(o_timeout_stb), 0);
      chk({tag, "_start"}, 32'(o_start_stb), 0);
      chk({tag, "_pdata"}, 32'(o_parallel_data), 0);
   endtask

   task automatic do_xfer(input logic [3:0] eg, input logic [7:0] ew, input bit chk_gap,
                          input bit late_en, input logic [7:0] late_word);
      int n, t, strobes, bad, t_strobe, t_fall, t_to;
      logic pb;
      exp_q.push_back({eg, ew});
      n = 0;
      do begin @(negedge clk); n++; end while (o_grant == '0 && n < 2000);
      chk("grant", 32'(o_grant), 32'(eg));
      chk("pdata", 32'(o_parallel_data), 32'(ew));
      if (chk_gap) chk("idle_gap", n - 1, 1);
      if (late_en) i_data[7:0] = late_word;
      t = 0; strobes = 0; bad = 0; t_strobe = -1; t_fall = -1; t_to = -1;
      pb = sr_busy;
      while (o_ack == '0 && t < 2000) begin
         if (o_start_stb) begin strobes++; t_strobe = t; end
         if (o_timeout_stb) t_to = t;
         if (o_grant !== eg || o_active !== 1'b1) bad++;
         @(negedge clk); t++;
         if (pb && !sr_busy) t_fall = t;
         pb = sr_busy;
      end
      chk("ack", 32'(o_ack), 32'(eg));
      chk("one_strobe", strobes, 1);
      chk("strobe_latency", t_strobe, 1);
      chk("grant_hold", bad, 0);
      if (busy_en) begin
         chk("ack_after_busy", t - t_fall, 1);
         chk("no_timeout", t_to, -1);
      end else begin
         chk("timeout_latency", t_to - t_strobe, BUSY_TIMEOUT);
         chk("ack_after_timeout", t - t_to, 1);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      i_req  = '0;
      i_data = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single request on channel 1 with a long transfer
      busy_len = 400;
      i_data[15:8] = 8'hA5;
      i_req = 4'b0010;
      do_xfer(4'b0010, 8'hA5, 1'b0, 1'b0, 8'h00);
      i_req = '0;
      @(negedge clk);
      chk("post_ack_grant", 32'(o_grant), 0);
      chk("post_ack_active", 32'(o_active), 0);

      // fairness after channel 1 was served
      busy_len = 5;
      i_data = {8'hD3, 8'hC2, 8'hB1, 8'hB0};
      i_req = 4'b1011;
      do_xfer(4'b1000, 8'hD3, 1'b0, 1'b0, 8'h00);
      i_req = 4'b0011;
      do_xfer(4'b0001, 8'hB0, 1'b1, 1'b0, 8'h00);
      i_req = 4'b0010;
      do_xfer(4'b0010, 8'hB1, 1'b1, 1'b0, 8'h00);
      i_req = '0;

      // data sampled only at grant
      i_data[7:0] = 8'h3C;
      i_req = 4'b0001;
      do_xfer(4'b0001, 8'h3C, 1'b1, 1'b1, 8'hFF);
      i_req = '0;
      repeat (2) @(negedge clk);

      // busy never rises: timeout path
      busy_en = 1'b0;
      i_data[7:0] = 8'h5A;
      i_req = 4'b0001;
      do_xfer(4'b0001, 8'h5A, 1'b0, 1'b0, 8'h00);
      i_req = '0;
      @(negedge clk);
      chk("timeout_idle_active", 32'(o_active), 0);
      busy_en = 1'b1;

      // all four requesting continuously from reset
      rst_n = 1'b0;
      busy_len = 3;
      i_data = {8'h13, 8'h12, 8'h11, 8'h10};
      i_req = 4'b1111;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_xfer(4'b0001, 8'h10, 1'b0, 1'b0, 8'h00);
      do_xfer(4'b0010, 8'h11, 1'b1, 1'b0, 8'h00);
      do_xfer(4'b0100, 8'h12, 1'b1, 1'b0, 8'h00);
      do_xfer(4'b1000, 8'h13, 1'b1, 1'b0, 8'h00);
      do_xfer(4'b0001, 8'h10, 1'b1, 1'b0, 8'h00);
      i_req = '0;
      repeat (2) @(negedge clk);

      // asynchronous reset in WAIT_DONE, then a pending request is served
      begin
         int n;
         busy_len = 50;
         i_req = 4'b0001;
         n = 0;
         while (!(o_grant == 4'b0001 && sr_busy) && n < 200) begin @(negedge clk); n++; end
         chk("reached_wait_done", 32'(sr_busy), 1);
         repeat (3) @(negedge clk);
         #2 rst_n = 1'b0;
         #1 chk_reset_outputs("async_reset");
         i_req = 4'b0100;
         i_data[23:16] = 8'h77;
         busy_len = 6;
         @(negedge clk);
         chk("reset_no_ack", 32'(o_ack), 0);
         rst_n = 1'b1;
         do_xfer(4'b0100, 8'h77, 1'b0, 1'b0, 8'h00);
         i_req = '0;
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
